// File: rtl/axi_arb_pkg.sv
// Shared types and the round-robin search used by the AXI write arbiter.
// Searches start one past the last winner and wrap, so every requester gets a turn.
package axi_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    localparam int MAX_NUM = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First asserted request at last+1, last+2, ... modulo num.
    function automatic pick_t rr_pick(input logic [MAX_NUM-1:0] req,
                                      input logic [3:0]         last,
                                      input int                 num);
        pick_t res;
        int    idx;
        res = '0;
        for (int k = 1; k <= MAX_NUM; k++) begin
            idx = (int'(last) + k) % num;
            if (k <= num && !res.found && req[idx[3:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin selector: picks the next requester after 'last'.
module axi_rr_pick
    import axi_arb_pkg::*;
#(
    parameter int NUM = 4,
    parameter int IW  = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  last,
    output logic           found,
    output logic [IW-1:0]  idx
);

    pick_t pick;

    always_comb begin
        pick = rr_pick(MAX_NUM'(req), 4'(last), NUM);
    end

    assign found = pick.found;
    assign idx   = IW'(pick.idx);

endmodule

// File: rtl/axi_wr_arbiter.sv
// N-to-1 round-robin arbiter for one AXI write port; the grant is held from
// AW selection through the B handshake so W beats and B always match the winner.
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM    = 4,
    parameter int ASIZE  = 32,
    parameter int DSIZE  = 64,
    parameter int IDSIZE = 4,
    parameter int LSIZE  = 8
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [NUM-1:0]        s_awvalid,
    output logic [NUM-1:0]        s_awready,
    input  logic [NUM*ASIZE-1:0]  s_awaddr,
    input  logic [NUM*LSIZE-1:0]  s_awlen,
    input  logic [NUM-1:0]        s_wvalid,
    output logic [NUM-1:0]        s_wready,
    input  logic [NUM*DSIZE-1:0]  s_wdata,
    input  logic [NUM-1:0]        s_wlast,
    output logic [NUM-1:0]        s_bvalid,
    input  logic [NUM-1:0]        s_bready,
    output logic [1:0]            s_bresp,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [IDSIZE-1:0]     m_awid,
    output logic [ASIZE-1:0]      m_awaddr,
    output logic [LSIZE-1:0]      m_awlen,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DSIZE-1:0]      m_wdata,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [IDSIZE-1:0]     m_bid,
    input  logic [1:0]            m_bresp,
    output logic [NUM-1:0]        grant,
    output logic                  busy,
    output logic                  len_err,
    output logic                  id_err
);

    localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

    state_t            state;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     rr_last;
    logic [LSIZE-1:0]  beats;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [NUM-1:0]    onehot;

    logic [ASIZE-1:0]  aw_addr [NUM];
    logic [LSIZE-1:0]  aw_len  [NUM];
    logic [DSIZE-1:0]  w_data  [NUM];

    for (genvar i = 0; i < NUM; i++) begin : g_unpack
        assign aw_addr[i] = s_awaddr[i*ASIZE +: ASIZE];
        assign aw_len[i]  = s_awlen[i*LSIZE +: LSIZE];
        assign w_data[i]  = s_wdata[i*DSIZE +: DSIZE];
    end

    axi_rr_pick #(.NUM(NUM), .IW(IW)) u_pick (
        .req   (s_awvalid),
        .last  (rr_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign onehot = NUM'(1) << gnt_idx;
    assign busy   = (state != ST_IDLE);
    assign grant  = busy ? onehot : '0;

    // Every mux output is forced to zero outside its own phase, so IDLE and
    // reset present a fully quiet port.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bresp   = '0;
        m_awvalid = 1'b0;
        m_awid    = '0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        case (state)
            ST_ADDR: begin
                m_awvalid = s_awvalid[gnt_idx];
                s_awready = onehot & {NUM{m_awready}};
                m_awid    = IDSIZE'(gnt_idx);
                m_awaddr  = aw_addr[gnt_idx];
                m_awlen   = aw_len[gnt_idx];
            end
            ST_DATA: begin
                m_wvalid = s_wvalid[gnt_idx];
                s_wready = onehot & {NUM{m_wready}};
                m_wdata  = w_data[gnt_idx];
                m_wlast  = s_wlast[gnt_idx];
            end
            ST_RESP: begin
                s_bvalid = onehot & {NUM{m_bvalid}};
                m_bready = s_bready[gnt_idx];
                s_bresp  = m_bresp;
            end
            default: ;
        endcase
    end

    // NOTE: asynchronous active-low reset; every register, including the
    // sticky error flags, is cleared here and nowhere else.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state   <= ST_IDLE;
            gnt_idx <= '0;
            rr_last <= IW'(NUM - 1);
            beats   <= '0;
            len_err <= 1'b0;
            id_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of its peers.
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        gnt_idx <= pick_idx;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_awvalid && m_awready) begin
                        beats <= aw_len[gnt_idx];
                        state <= ST_DATA;
                    end else if (!m_awvalid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (m_wvalid && m_wready) begin
                        if (m_wlast != (beats == '0))
                            len_err <= 1'b1;
                        if (beats != '0)
                            beats <= beats - 1'b1;
                        if (m_wlast)
                            state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_bvalid && m_bready) begin
                        if (m_bid != IDSIZE'(gnt_idx))
                            id_err <= 1'b1;
                        rr_last <= gnt_idx;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter (NUM=4): arbitration order,
// grant hold, length/ID error flags and asynchronous reset.
module tb_axi_wr_arbiter;

    localparam int NUM    = 4;
    localparam int ASIZE  = 32;
    localparam int DSIZE  = 64;
    localparam int IDSIZE = 4;
    localparam int LSIZE  = 8;

    logic                 axi_aclk = 1'b0;
    logic                 axi_aresetn;
    logic [NUM-1:0]       s_awvalid, s_awready;
    logic [NUM*ASIZE-1:0] s_awaddr;
    logic [NUM*LSIZE-1:0] s_awlen;
    logic [NUM-1:0]       s_wvalid, s_wready;
    logic [NUM*DSIZE-1:0] s_wdata;
    logic [NUM-1:0]       s_wlast;
    logic [NUM-1:0]       s_bvalid, s_bready;
    logic [1:0]           s_bresp;
    logic                 m_awvalid, m_awready;
    logic [IDSIZE-1:0]    m_awid;
    logic [ASIZE-1:0]     m_awaddr;
    logic [LSIZE-1:0]     m_awlen;
    logic                 m_wvalid, m_wready;
    logic [DSIZE-1:0]     m_wdata;
    logic                 m_wlast;
    logic                 m_bvalid, m_bready;
    logic [IDSIZE-1:0]    m_bid;
    logic [1:0]           m_bresp;
    logic [NUM-1:0]       grant;
    logic                 busy, len_err, id_err;

    int total = 0;
    int bad   = 0;

    always #5 axi_aclk = ~axi_aclk;

    axi_wr_arbiter #(
        .NUM(NUM), .ASIZE(ASIZE), .DSIZE(DSIZE), .IDSIZE(IDSIZE), .LSIZE(LSIZE)
    ) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .grant(grant), .busy(busy), .len_err(len_err), .id_err(id_err)
    );

    task automatic clear_inputs;
        s_awvalid = '0; s_awaddr = '0; s_awlen = '0;
        s_wvalid  = '0; s_wdata  = '0; s_wlast = '0; s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic tick;
        @(negedge axi_aclk);
    endtask

    task automatic do_reset;
        clear_inputs();
        axi_aresetn = 1'b0;
        repeat (2) tick();
        axi_aresetn = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        axi_aresetn = 1'b0;
        s_awvalid = 4'hF;
        m_awready = 1'b1;
        s_wvalid = 4'hF;
        m_wready = 1'b1;
        m_bvalid = 1'b1;
        repeat (2) tick();
        #1;
        total++; if (grant !== 4'h0) begin bad++; $display("FAIL reset_grant got=%h exp=%h", grant, 4'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b000) begin bad++; $display("FAIL reset_m_valid got=%b exp=000", {m_awvalid, m_wvalid, m_bready}); end
        total++; if ({s_awready, s_wready, s_bvalid} !== 12'h000) begin bad++; $display("FAIL reset_s_ready got=%h exp=000", {s_awready, s_wready, s_bvalid}); end
        total++; if ({len_err, id_err} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {len_err, id_err}); end
        total++; if (m_awaddr !== '0 || m_wdata !== '0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", m_awaddr, m_wdata); end
        do_reset();
    endtask

    task automatic test_single;
        do_reset();
        s_awvalid = 4'b0010;
        s_awaddr[1*ASIZE +: ASIZE] = 32'h0000_1000;
        s_awlen[1*LSIZE +: LSIZE] = 8'd3;
        m_awready = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
        tick(); #1;
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant got=%h exp=%h", grant, 4'b0010); end
        total++; if (m_awvalid !== 1'b1 || m_awid !== 4'd1) begin bad++; $display("FAIL single_aw got=%b/%h exp=1/1", m_awvalid, m_awid); end
        total++; if (m_awaddr !== 32'h0000_1000 || m_awlen !== 8'd3) begin bad++; $display("FAIL single_awaddr got=%h/%h exp=1000/3", m_awaddr, m_awlen); end
        total++; if (s_awready !== 4'b0010) begin bad++; $display("FAIL single_awready got=%b exp=0010", s_awready); end
        tick();
        s_awvalid = '0;
        m_wready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_wvalid = 4'b0010;
            s_wdata[1*DSIZE +: DSIZE] = 64'hDEAD_BEEF_0000_0000 + 64'(b);
            s_wlast = (b == 3) ? 4'b0010 : 4'b0000;
            #1;
            total++; if (m_wvalid !== 1'b1 || s_wready !== 4'b0010) begin bad++; $display("FAIL single_w%0d valid/ready got=%b/%b exp=1/0010", b, m_wvalid, s_wready); end
            total++; if (m_wdata !== 64'hDEAD_BEEF_0000_0000 + 64'(b) || m_wlast !== (b == 3)) begin bad++; $display("FAIL single_w%0d data got=%h/%b exp=%h/%b", b, m_wdata, m_wlast, 64'hDEAD_BEEF_0000_0000 + 64'(b), b == 3); end
            tick();
        end
        s_wvalid = '0;
        s_wlast = '0;
        m_bvalid = 1'b1;
        m_bid = 4'd1;
        m_bresp = 2'b10;
        s_bready = 4'b0010;
        #1;
        total++; if (s_bvalid !== 4'b0010 || s_bresp !== 2'b10 || m_bready !== 1'b1) begin bad++; $display("FAIL single_b got=%b/%b/%b exp=0010/10/1", s_bvalid, s_bresp, m_bready); end
        tick();
        m_bvalid = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || grant !== 4'h0) begin bad++; $display("FAIL single_done got=%b/%h exp=0/0", busy, grant); end
        total++; if ({len_err, id_err} !== 2'b00) begin bad++; $display("FAIL single_err got=%b exp=00", {len_err, id_err}); end
    endtask

    task automatic test_round_robin;
        logic [NUM-1:0] exp_g;
        do_reset();
        s_awvalid = 4'hF;
        s_wvalid = 4'hF;
        s_wlast = 4'hF;
        s_bready = 4'hF;
        m_awready = 1'b1;
        m_wready = 1'b1;
        m_bvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            m_bid = 4'(k % 4);
            #1;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle%0d got=%b exp=0", k, busy); end
            tick(); #1;
            total++; if (grant !== exp_g || m_awid !== 4'(k % 4)) begin bad++; $display("FAIL rr_grant%0d got=%b/%h exp=%b/%h", k, grant, m_awid, exp_g, k % 4); end
            repeat (3) tick();
        end
        total++; if ({len_err, id_err} !== 2'b00) begin bad++; $display("FAIL rr_err got=%b exp=00", {len_err, id_err}); end
        clear_inputs();
    endtask

    task automatic test_hold;
        do_reset();
        s_awvalid = 4'b0001;
        s_awaddr[0 +: ASIZE] = 32'h0000_2000;
        s_awlen[0 +: LSIZE] = 8'd1;
        m_awready = 1'b1;
        s_wvalid = 4'b0001;
        s_wdata[0 +: DSIZE] = 64'h11;
        tick(); #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL hold_grant0 got=%b exp=0001", grant); end
        total++; if (m_wvalid !== 1'b0 || s_wready !== 4'h0) begin bad++; $display("FAIL hold_early_w got=%b/%b exp=0/0000", m_wvalid, s_wready); end
        tick();
        s_awvalid = 4'b0100;
        s_awaddr[2*ASIZE +: ASIZE] = 32'h0000_3000;
        m_wready = 1'b1;
        #1;
        total++; if (s_awready !== 4'h0 || grant !== 4'b0001 || m_wvalid !== 1'b1) begin bad++; $display("FAIL hold_data1 got=%b/%b/%b exp=0000/0001/1", s_awready, grant, m_wvalid); end
        tick();
        s_wlast = 4'b0001;
        #1;
        total++; if (s_awready !== 4'h0 || grant !== 4'b0001) begin bad++; $display("FAIL hold_data2 got=%b/%b exp=0000/0001", s_awready, grant); end
        tick();
        s_wvalid = '0;
        s_wlast = '0;
        m_bvalid = 1'b1;
        m_bid = 4'd0;
        s_bready = 4'b0001;
        #1;
        total++; if (s_awready !== 4'h0 || grant !== 4'b0001 || s_bvalid !== 4'b0001) begin bad++; $display("FAIL hold_resp got=%b/%b/%b exp=0000/0001/0001", s_awready, grant, s_bvalid); end
        tick();
        m_bvalid = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || s_awready !== 4'h0) begin bad++; $display("FAIL hold_gap got=%b/%b exp=0/0000", busy, s_awready); end
        tick(); #1;
        total++; if (grant !== 4'b0100 || s_awready !== 4'b0100 || m_awaddr !== 32'h0000_3000) begin bad++; $display("FAIL hold_grant2 got=%b/%b/%h exp=0100/0100/3000", grant, s_awready, m_awaddr); end
        s_awvalid = '0;
        tick(); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_abandon got=%b exp=0", busy); end
        // rr_last is still 0 after the abandoned AW, so requester 1 outranks 0.
        s_awvalid = 4'b0011;
        tick(); #1;
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL hold_rr_kept got=%b exp=0010", grant); end
        total++; if ({len_err, id_err} !== 2'b00) begin bad++; $display("FAIL hold_err got=%b exp=00", {len_err, id_err}); end
        s_awvalid = '0;
        tick();
        clear_inputs();
    endtask

    task automatic test_len_err;
        int fwd;
        do_reset();
        s_awvalid = 4'b0001;
        s_awlen[0 +: LSIZE] = 8'd3;
        m_awready = 1'b1;
        tick();
        tick();
        s_awvalid = '0;
        s_wvalid = 4'b0001;
        m_wready = 1'b1;
        tick();
        s_wlast = 4'b0001;
        tick();
        m_bvalid = 1'b1;
        s_bready = 4'b0001;
        #1;
        total++; if (len_err !== 1'b1) begin bad++; $display("FAIL len_early_flag got=%b exp=1", len_err); end
        total++; if (m_wvalid !== 1'b0 || s_bvalid !== 4'b0001) begin bad++; $display("FAIL len_early_resp got=%b/%b exp=0/0001", m_wvalid, s_bvalid); end
        tick();
        clear_inputs();
        #1;
        total++; if (busy !== 1'b0 || len_err !== 1'b1) begin bad++; $display("FAIL len_early_done got=%b/%b exp=0/1", busy, len_err); end

        do_reset();
        s_awvalid = 4'b0001;
        s_awlen[0 +: LSIZE] = 8'd3;
        m_awready = 1'b1;
        tick();
        tick();
        s_awvalid = '0;
        m_wready = 1'b1;
        fwd = 0;
        for (int b = 1; b <= 6; b++) begin
            s_wvalid = 4'b0001;
            s_wlast = (b == 6) ? 4'b0001 : 4'b0000;
            #1;
            if (m_wvalid && m_wready) fwd++;
            if (b == 4) begin
                total++; if (len_err !== 1'b0) begin bad++; $display("FAIL len_late_pre got=%b exp=0", len_err); end
            end
            if (b == 5) begin
                total++; if (len_err !== 1'b1) begin bad++; $display("FAIL len_late_flag got=%b exp=1", len_err); end
            end
            tick();
        end
        s_wvalid = '0;
        s_wlast = '0;
        m_bvalid = 1'b1;
        s_bready = 4'b0001;
        #1;
        total++; if (fwd !== 6) begin bad++; $display("FAIL len_late_beats got=%0d exp=6", fwd); end
        total++; if (s_bvalid !== 4'b0001) begin bad++; $display("FAIL len_late_resp got=%b exp=0001", s_bvalid); end
        tick();
        clear_inputs();
    endtask

    task automatic test_id_err;
        do_reset();
        s_awvalid = 4'b0010;
        m_awready = 1'b1;
        tick();
        tick();
        s_awvalid = '0;
        s_wvalid = 4'b0010;
        s_wlast = 4'b0010;
        m_wready = 1'b1;
        tick();
        s_wvalid = '0;
        s_wlast = '0;
        m_bvalid = 1'b1;
        m_bid = 4'd3;
        s_bready = 4'b0010;
        #1;
        total++; if (s_bvalid !== 4'b0010 || id_err !== 1'b0) begin bad++; $display("FAIL id_resp got=%b/%b exp=0010/0", s_bvalid, id_err); end
        tick();
        m_bvalid = 1'b0;
        #1;
        total++; if (id_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL id_flag got=%b/%b exp=1/0", id_err, busy); end
        // rr_last is now 1: requester 2 must win over requester 0.
        s_awvalid = 4'b0101;
        tick(); #1;
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL id_rr_last got=%b exp=0100", grant); end
        s_awvalid = '0;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        s_awvalid = 4'b0010;
        s_awlen[1*LSIZE +: LSIZE] = 8'd3;
        m_awready = 1'b1;
        tick();
        tick();
        s_awvalid = '0;
        s_wvalid = 4'b0010;
        s_wdata[1*DSIZE +: DSIZE] = 64'h55;
        m_wready = 1'b1;
        tick();
        #1;
        total++; if (m_wvalid !== 1'b1) begin bad++; $display("FAIL rstmid_beat2 got=%b exp=1", m_wvalid); end
        #1 axi_aresetn = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || grant !== 4'h0) begin bad++; $display("FAIL rstmid_state got=%b/%b exp=0/0000", busy, grant); end
        total++; if (m_wvalid !== 1'b0 || s_wready !== 4'h0 || m_wdata !== '0) begin bad++; $display("FAIL rstmid_w got=%b/%b/%h exp=0/0000/0", m_wvalid, s_wready, m_wdata); end
        tick();
        axi_aresetn = 1'b1;
        clear_inputs();
        s_awvalid = 4'b0011;
        m_awready = 1'b1;
        tick(); #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rstmid_prio got=%b exp=0001", grant); end
        s_awvalid = '0;
        tick();
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        axi_aresetn = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_len_err();
        test_id_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
Synthesizable N-to-1 round-robin arbiter that shares one downstream AXI write port (AW/W/B) between NUM upstream requesters. The grant is held from AW selection through the B handshake, so W beats and the response always belong to the granted requester. It sits between DMA/stream writers and the memory-side AXI port that the mirror BFM monitors in simulation.

Parameters:
NUM, 4, number of requesters (2..16)
ASIZE, 32, address width
DSIZE, 64, data width
IDSIZE, 4, AXI ID width; must be >= clog2(NUM)
LSIZE, 8, burst length field width

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
s_awvalid / s_awready  in / out  NUM  per-requester AW handshake
s_awaddr  in  NUM*ASIZE  packed AW addresses, requester i at [i*ASIZE+:ASIZE]
s_awlen  in  NUM*LSIZE  packed burst lengths minus 1
s_wvalid / s_wready  in / out  NUM  per-requester W handshake
s_wdata  in  NUM*DSIZE  packed write data
s_wlast  in  NUM  per-requester last beat
s_bvalid / s_bready  out / in  NUM  per-requester B handshake
s_bresp  out  2  response, valid only on the granted requester's s_bvalid
m_awvalid / m_awready  out / in  1  downstream AW handshake
m_awid  out  IDSIZE  granted requester index, zero-extended
m_awaddr / m_awlen  out  ASIZE / LSIZE  muxed AW fields
m_wvalid / m_wready  out / in  1  downstream W handshake
m_wdata / m_wlast  out  DSIZE / 1  muxed W fields
m_bvalid / m_bready  in / out  1  downstream B handshake
m_bid / m_bresp  in  IDSIZE / 2  downstream response
grant  out  NUM  one-hot current grant; zero in IDLE
busy  out  1  state != IDLE
len_err  out  1  sticky: wlast position disagreed with awlen
id_err  out  1  sticky: m_bid != granted index at B handshake

Behaviour:
- Reset (async, axi_aresetn low): state IDLE, grant=0, rr_last=NUM-1 (requester 0 highest priority first), beat counter 0, len_err=id_err=0. All valid/ready outputs 0 and muxed data outputs 0. Reset mid-burst abandons the transaction with no flush.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any s_awvalid, pick the first asserted index searching rr_last+1, rr_last+2, ... with wrap modulo NUM. Register grant and go to ADDR. Latency: s_awvalid seen at edge n gives m_awvalid high in cycle n+1.
- ADDR: m_awvalid=s_awvalid[g]; s_awready[g]=m_awready; m_awaddr, m_awlen and m_awid muxed combinationally from g. On handshake: load beats=awlen[g] and go to DATA. If s_awvalid[g] drops before handshake, return to IDLE with rr_last unchanged.
- DATA: m_wvalid=s_wvalid[g]; s_wready[g]=m_wready; wdata and wlast muxed. Each handshake decrements beats. A handshake with wlast goes to RESP. len_err is set if wlast arrives while beats!=0, or if beats==0 and wlast is low; beats saturates at 0 and forwarding continues until wlast.
- RESP: s_bvalid[g]=m_bvalid; m_bready=s_bready[g]; s_bresp=m_bresp. On handshake: id_err is set if m_bid!=g, rr_last<=g, and go to IDLE.
- Non-granted s_*ready and s_bvalid are 0 in every state. No W beat is accepted outside DATA; data-before-address waits.
- Minimum back-to-back: one IDLE cycle between transactions. An awlen of 0 gives a single-beat DATA phase.
- Sticky errors clear only on reset.

Decomposition:
- Package axi_arb_pkg: state enum type, function rr_pick(req, last) returning the index plus a found flag.
- One sub-module, axi_rr_pick: combinational round-robin selector parameterized by NUM, used by IDLE. Everything else stays in axi_wr_arbiter.

Test Plan:
- Single requester: req1 AW addr 0x1000 with awlen=3 and 4 beats -> m_awid=1, m_awaddr=0x1000, 4 m_w beats with wlast on beat 4, then s_bvalid[1] only; busy returns to 0.
- All 4 requesters hold awvalid continuously -> grant sequence 0,1,2,3,0 with one IDLE cycle between each.
- Req2 asserts awvalid while req0 is in DATA -> req2 not granted until req0's B handshake; s_awready[2] stays 0 throughout.
- awlen=3 but wlast on beat 2 -> len_err=1, FSM goes to RESP after beat 2; second case with wlast late on beat 6 -> 6 beats forwarded, len_err=1.
- m_bid=3 while the grant is 1 -> id_err=1; transaction still completes and rr_last=1.
- axi_aresetn pulsed low during DATA beat 2 -> all outputs 0 immediately; after release, req0 has priority.
